stream_differ: RTL and testbench



---
 rtl/stream_differ.sv | 135 +++++++++++++
 tb/tb_stream_differ.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_differ.sv
`timescale 1ns/1ps
// stream_differ
// AXI-Stream delta decoder: recovers original samples from a running-sum
// stream. Each accepted beat x produces x - prev (mod 2^DATA_W), where prev
// is the previous input of the same frame (0 at frame start / after reset).
// A main output register plus a one-entry skid register give full throughput
// while s_ready stays a pure register output.
//
// Ports
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   s_valid    : input beat valid
//   s_data     : input running-sum sample
//   s_last     : input last beat of frame
//   s_ready    : input ready (registered)
//   m_valid    : output beat valid
//   m_data     : decoded difference
//   m_last     : copy of s_last for the beat
//   m_ready    : output ready
//   frame_cnt  : number of accepted beats with s_last=1 (wraps)
module stream_differ #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic [15:0]       frame_cnt
);

    logic              ready_en_q;
    logic [DATA_W-1:0] prev_q,      prev_d;
    logic              m_valid_q,   m_valid_d;
    logic [DATA_W-1:0] m_data_q,    m_data_d;
    logic              m_last_q,    m_last_d;
    logic              k_valid_q,   k_valid_d;
    logic [DATA_W-1:0] k_data_q,    k_data_d;
    logic              k_last_q,    k_last_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic              accept;
    logic              drain;
    logic [DATA_W-1:0] beat_data;

    // Registered ready: depends only on flops, never on m_ready.
    assign s_ready   = ready_en_q & ~k_valid_q;
    assign accept    = s_valid & s_ready;
    assign drain     = m_valid_q & m_ready;
    assign beat_data = s_data - prev_q;

    always_comb begin
        prev_d      = prev_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        k_valid_d   = k_valid_q;
        k_data_d    = k_data_q;
        k_last_d    = k_last_q;
        frame_cnt_d = frame_cnt_q;

        if (accept) begin
            prev_d = s_last ? '0 : s_data;
            if (s_last) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end

        if (drain) begin
            if (k_valid_q) begin
                // Skid entry is older than any new beat: it moves up first.
                m_valid_d = 1'b1;
                m_data_d  = k_data_q;
                m_last_d  = k_last_q;
                k_valid_d = accept;
                if (accept) begin
                    k_data_d = beat_data;
                    k_last_d = s_last;
                end
            end else begin
                m_valid_d = accept;
                if (accept) begin
                    m_data_d = beat_data;
                    m_last_d = s_last;
                end
            end
        end else if (!m_valid_q) begin
            m_valid_d = accept;
            if (accept) begin
                m_data_d = beat_data;
                m_last_d = s_last;
            end
        end else if (accept) begin
            // Main register is stalled: park the beat in the skid entry.
            k_valid_d = 1'b1;
            k_data_d  = beat_data;
            k_last_d  = s_last;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en_q  <= 1'b0;
            prev_q      <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            k_valid_q   <= 1'b0;
            k_data_q    <= '0;
            k_last_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            ready_en_q  <= 1'b1;
            prev_q      <= prev_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            k_valid_q   <= k_valid_d;
            k_data_q    <= k_data_d;
            k_last_q    <= k_last_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_stream_differ.sv
`timescale 1ns/1ps
module tb_stream_differ;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data  = '0;
    logic        s_last  = 1'b0;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_ready = 1'b0;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    stream_differ #(.DATA_W(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .frame_cnt (frame_cnt)
    );

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       mon_e;
    beat_t       held;
    bit          hold_pend = 1'b0;
    bit          bp_rand   = 1'b0;
    int unsigned n_pass    = 0;
    int unsigned n_total   = 0;

    logic [31:0] bp_v [6] = '{32'd1, 32'd3, 32'd6, 32'd10, 32'd15, 32'd21};
    logic [31:0] bp_e [6] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // One clock cycle; reports whether the current beat was accepted at the edge.
    task automatic step(output bit acc);
        @(negedge clk);
        acc = s_valid && s_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input bit last, input logic [31:0] exp_d,
                        input bit push, output int unsigned cycles);
        bit acc;
        acc    = 1'b0;
        cycles = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!acc && cycles < 1000) begin
            step(acc);
            cycles++;
        end
        if (!acc) begin
            n_total++;
            $display("FAIL accept_timeout: got no accept, expected accept within 1000 cycles");
        end else if (push) begin
            exp_q.push_back(beat_t'({last, exp_d}));
        end
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        exp_q.delete();
        #10 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("queue_drained", exp_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard on each output handshake and checks hold rules.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    check("hold_valid", m_valid, 1);
                    check("hold_beat", {m_last, m_data}, held);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL out_unexpected: got beat 0x%0h, expected no beat", {m_last, m_data});
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("out_beat", {m_last, m_data}, mon_e);
                    end
                end
                hold_pend = m_valid && !m_ready;
                held      = {m_last, m_data};
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_rand) m_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int unsigned cyc;
        int unsigned tot;
        int unsigned idx;
        bit          a;
        bit          lst;
        logic [31:0] acc;
        logic [31:0] d;
        logic [31:0] sd;

        // Reset state
        #3;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        check("s_ready_before_edge", s_ready, 0);
        @(posedge clk);
        #1;
        check("s_ready_after_edge", s_ready, 1);
        m_ready = 1'b1;

        // Basic decode, one beat per cycle
        tot = 0;
        send(32'd5, 1'b0, 32'd5, 1'b1, cyc);  tot += cyc;
        check("latency", {m_valid, m_data}, {1'b1, 32'd5});
        send(32'd12, 1'b0, 32'd7, 1'b1, cyc); tot += cyc;
        send(32'd20, 1'b0, 32'd8, 1'b1, cyc); tot += cyc;
        send(32'd20, 1'b0, 32'd0, 1'b1, cyc); tot += cyc;
        s_valid = 1'b0;
        check("throughput_cycles", tot, 4);
        wait_drain();
        do_reset();

        // Wrap-around and frame restart
        send(32'd3, 1'b0, 32'd3, 1'b1, cyc);
        send(32'd1, 1'b1, 32'hFFFF_FFFE, 1'b1, cyc);
        send(32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b1, cyc);
        send(32'd4, 1'b1, 32'd5, 1'b1, cyc);
        s_valid = 1'b0;
        wait_drain();
        do_reset();

        // Frames
        send(32'd10, 1'b0, 32'd10, 1'b1, cyc);
        send(32'd15, 1'b1, 32'd5, 1'b1, cyc);
        send(32'd4, 1'b0, 32'd4, 1'b1, cyc);
        send(32'd9, 1'b1, 32'd5, 1'b1, cyc);
        s_valid = 1'b0;
        check("frame_cnt_2", frame_cnt, 2);
        wait_drain();

        // Back-pressure: M then K fill, s_ready drops, then clean drain
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_last  = 1'b0;
        idx     = 0;
        s_data  = bp_v[0];
        for (int k = 0; k < 3; k++) begin
            step(a);
            if (a) begin
                exp_q.push_back(beat_t'({1'b0, bp_e[idx]}));
                idx++;
                s_data = bp_v[idx];
            end
        end
        check("bp_accepted", idx, 2);
        check("bp_s_ready_low", s_ready, 0);
        check("bp_m_data_held", m_data, 1);
        m_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("bp_no_gap", m_valid, 1);
            step(a);
            if (a) begin
                exp_q.push_back(beat_t'({1'b0, bp_e[idx]}));
                idx++;
                if (idx < 6) s_data = bp_v[idx];
                else s_valid = 1'b0;
            end
            if (k == 0) begin
                check("bp_s_ready_back", s_ready, 1);
                check("bp_k_to_m", m_data, 2);
            end
        end
        check("bp_all_accepted", idx, 6);
        s_valid = 1'b0;
        wait_drain();

        // Random valid/ready; deltas integrated per frame form the input stream
        acc = 32'd21;
        bp_rand = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                step(a);
            end
            d   = $urandom;
            lst = ($urandom_range(0, 7) == 0);
            sd  = acc + d;
            send(sd, lst, d, 1'b1, cyc);
            acc = lst ? 32'd0 : sd;
        end
        s_valid = 1'b0;
        bp_rand = 1'b0;
        @(posedge clk);
        #1 m_ready = 1'b1;
        wait_drain();

        // Asynchronous reset with M and K both full
        m_ready = 1'b0;
        send(32'd100, 1'b0, 32'd0, 1'b0, cyc);
        send(32'd105, 1'b1, 32'd0, 1'b0, cyc);
        s_valid = 1'b0;
        check("pre_rst_s_ready", s_ready, 0);
        #2 reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_s_ready", s_ready, 0);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        check("mid_rst_m_data", m_data, 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_s_ready", s_ready, 1);
        m_ready = 1'b1;
        send(32'd7, 1'b0, 32'd7, 1'b1, cyc);
        s_valid = 1'b0;
        check("post_rst_out", {m_valid, m_data}, {1'b1, 32'd7});
        wait_drain();
        check("post_rst_frame_cnt", frame_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
